// File: rtl/instr_prefetch_unit_if.sv
// Bus bundle between the prefetch unit, the instruction memory and the IF/ID register.
// The master side is the prefetch unit. The slave side is the memory plus the decode consumer.
interface instr_prefetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        op_valid;
    logic [31:0] op_instruction;
    logic [31:0] op_pc;
    logic        out_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output op_valid,
        output op_instruction,
        output op_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  op_valid,
        input  op_instruction,
        input  op_pc,
        output out_ready
    );
endinterface

// File: rtl/instr_prefetch_unit.sv
// RV32I fetch stage. It owns the fetch PC and issues one outstanding word read at a time.
// Returned words are queued in a small FIFO. Branch and jump redirects flush the FIFO and restart fetch.
module instr_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    instr_prefetch_unit_if.master  bus
);
    localparam int          PW   = $clog2(DEPTH);
    localparam int          CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t        state_reg;
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   addr_reg;
    logic          req_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW-1:0] count_next;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   target;
    logic          unused_pc_bits;

    assign target         = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Data returned while discarding, or during a redirect cycle, belongs to the wrong path.
    assign accept        = req_reg && bus.imem_ack;
    assign push          = accept && (state_reg == FETCH) && !redirect_valid;
    assign head_valid    = (count_reg != '0) && !redirect_valid;
    assign pop           = head_valid && bus.out_ready;
    assign count_next    = count_reg + CW'(push) - CW'(pop);
    assign fetch_pc_next = push ? fetch_pc_reg + 32'd4 : fetch_pc_reg;

    assign bus.imem_req       = req_reg;
    assign bus.imem_addr      = addr_reg;
    assign bus.op_valid       = head_valid;
    assign bus.op_instruction = head_valid ? instr_mem[rd_ptr_reg] : NOP;
    assign bus.op_pc          = head_valid ? pc_mem[rd_ptr_reg] : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= FETCH;
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= RESET_PC;
            req_reg      <= 1'b0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= target;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            // A request still in flight must complete before the target can be issued.
            if (req_reg && !bus.imem_ack) begin
                state_reg <= DISCARD;
            end else begin
                state_reg <= FETCH;
                req_reg   <= 1'b1;
                addr_reg  <= target;
            end
        end else if (state_reg == DISCARD) begin
            if (accept) begin
                state_reg <= FETCH;
                req_reg   <= 1'b1;
                addr_reg  <= fetch_pc_reg;
            end
        end else begin
            count_reg    <= count_next;
            fetch_pc_reg <= fetch_pc_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (!req_reg || accept) begin
                req_reg  <= (count_next < FULL);
                addr_reg <= fetch_pc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= bus.imem_rdata;
            pc_mem[wr_ptr_reg]    <= addr_reg;
        end
    end
endmodule
